// File: rtl/seq101_pkg.sv
// Shared types and defaults for the word-level "101" sequence detector.
// Controller and detector state encodings live here so checkers can bind to them.
package seq101_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    REPORT = 2'd2
  } ctrl_state_t;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    S1   = 2'd1,
    S2   = 2'd2,
    S3   = 2'd3
  } det_state_t;

endpackage

// File: rtl/seq101_core.sv
// Overlapping "101" Moore detector. hit flags that the state entered at this
// edge is S3; clear returns to INIT synchronously and wins over enable.
module seq101_core
  import seq101_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       xin,
  input  logic       enable,
  input  logic       clear,
  output logic       hit,
  output det_state_t state
);

  det_state_t state_q;
  det_state_t state_nxt;

  always_comb begin
    state_nxt = INIT;
    case (state_q)
      INIT:    state_nxt = xin ? S1 : INIT;
      S1:      state_nxt = xin ? S1 : S2;
      S2:      state_nxt = xin ? S3 : INIT;
      S3:      state_nxt = xin ? S1 : S2;
      default: state_nxt = INIT;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= INIT;
    end else if (clear) begin
      state_q <= INIT;
    end else if (enable) begin
      state_q <= state_nxt;
    end
  end

  assign hit   = enable && !clear && (state_nxt == S3);
  assign state = state_q;

endmodule

// File: rtl/seq101_scheduler.sv
// Accepts parallel words, feeds them MSB-first into the detector core and
// returns the per-word hit count. Detector history carries across words.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. in_ready and out_valid are pure decodes of the controller state,
// so neither depends combinationally on in_valid or out_ready; a producer may
// hold in_valid while in_ready is low and nothing is stored until it rises.
module seq101_scheduler
  import seq101_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  input  logic             clear_hist,
  output logic             in_ready,
  output logic             out_valid,
  output logic [CNT_W-1:0] out_hits,
  output logic             out_last_hit,
  input  logic             out_ready,
  output ctrl_state_t      dbg_state,
  output det_state_t       dbg_core_state
);

  localparam int BC_W = $clog2(WIDTH);
  localparam logic [BC_W-1:0]  LAST_BIT = BC_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  ctrl_state_t      state_q;
  ctrl_state_t      state_nxt;
  logic [WIDTH-1:0] shift_q;
  logic [BC_W-1:0]  bit_cnt_q;
  logic [CNT_W-1:0] hits_q;
  logic             last_hit_q;
  logic             core_en;
  logic             core_clr;
  logic             core_hit;
  logic             accept;
  logic             final_bit;

  assign accept    = (state_q == IDLE) && in_valid;
  assign final_bit = (bit_cnt_q == LAST_BIT);

  always_comb begin
    state_nxt = state_q;
    core_en   = 1'b0;
    core_clr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_nxt = SHIFT;
          core_clr  = clear_hist;
        end
      end
      SHIFT: begin
        core_en = 1'b1;
        if (final_bit) state_nxt = REPORT;
      end
      REPORT: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Datapath: loaded on accept, advanced one bit per SHIFT cycle, frozen otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      hits_q     <= '0;
      last_hit_q <= 1'b0;
    end else if (accept) begin
      shift_q    <= in_data;
      bit_cnt_q  <= '0;
      hits_q     <= '0;
      last_hit_q <= 1'b0;
    end else if (state_q == SHIFT) begin
      shift_q   <= {shift_q[WIDTH-2:0], 1'b0};
      bit_cnt_q <= bit_cnt_q + BC_W'(1);
      if (core_hit && (hits_q != CNT_MAX)) begin
        hits_q <= hits_q + CNT_W'(1);
      end
      if (final_bit) begin
        last_hit_q <= core_hit;
      end
    end
  end

  seq101_core u_core (
    .clk     (clk),
    .reset_n (reset_n),
    .xin     (shift_q[WIDTH-1]),
    .enable  (core_en),
    .clear   (core_clr),
    .hit     (core_hit),
    .state   (dbg_core_state)
  );

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = (state_q == REPORT);
  assign out_hits     = hits_q;
  assign out_last_hit = last_hit_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_seq101_scheduler.sv
// Self-checking bench for seq101_scheduler: scoreboard of {last_hit, hits}
// per word, plus a 16-bit/2-bit instance for counter saturation.
module tb_seq101_scheduler;
  import seq101_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  // ---------------- DUT (8-bit word, 4-bit count) ----------------
  logic        in_valid;
  logic [7:0]  in_data;
  logic        clear_hist;
  logic        in_ready;
  logic        out_valid;
  logic [3:0]  out_hits;
  logic        out_last_hit;
  logic        out_ready;
  ctrl_state_t dbg_state;
  det_state_t  dbg_core_state;

  seq101_scheduler #(.WIDTH(8), .CNT_W(4)) u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (in_valid),
    .in_data        (in_data),
    .clear_hist     (clear_hist),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .out_hits       (out_hits),
    .out_last_hit   (out_last_hit),
    .out_ready      (out_ready),
    .dbg_state      (dbg_state),
    .dbg_core_state (dbg_core_state)
  );

  // ---------------- saturation DUT (16-bit word, 2-bit count) ----------------
  logic        s_in_valid;
  logic [15:0] s_in_data;
  logic        s_clear_hist;
  logic        s_in_ready;
  logic        s_out_valid;
  logic [1:0]  s_out_hits;
  logic        s_out_last_hit;
  logic        s_out_ready;
  ctrl_state_t s_dbg_state;
  det_state_t  s_dbg_core_state;

  seq101_scheduler #(.WIDTH(16), .CNT_W(2)) u_sat (
    .clk            (clk),
    .reset_n        (reset_n),
    .in_valid       (s_in_valid),
    .in_data        (s_in_data),
    .clear_hist     (s_clear_hist),
    .in_ready       (s_in_ready),
    .out_valid      (s_out_valid),
    .out_hits       (s_out_hits),
    .out_last_hit   (s_out_last_hit),
    .out_ready      (s_out_ready),
    .dbg_state      (s_dbg_state),
    .dbg_core_state (s_dbg_core_state)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [4:0] exp_q[$];   // {last_hit, hits[3:0]}
  int         model_st = 0;  // 0=INIT 1=S1 2=S2 3=S3

  task automatic model_run(input logic [7:0] d, input logic c,
                           output int h, output logic l);
    h = 0;
    l = 1'b0;
    if (c) model_st = 0;
    for (int i = 7; i >= 0; i--) begin
      case (model_st)
        0: model_st = d[i] ? 1 : 0;
        1: model_st = d[i] ? 1 : 2;
        2: model_st = d[i] ? 3 : 0;
        default: model_st = d[i] ? 1 : 2;
      endcase
      l = (model_st == 3);
      if (l && h < 15) h++;
    end
  endtask

  always @(negedge clk) begin
    if (reset_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'(out_valid), 32'd0);
      end else begin
        logic [4:0] e;
        e = exp_q.pop_front();
        check("out_hits", 32'(out_hits), 32'(e[3:0]));
        check("out_last_hit", 32'(out_last_hit), 32'(e[4]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive_word(input logic [7:0] d, input logic c);
    int g = 0;
    in_valid   = 1'b1;
    in_data    = d;
    clear_hist = c;
    while (!in_ready && g < 100) begin
      @(posedge clk); #1;
      g++;
    end
    check("accept_in_time", 32'(g < 100), 32'd1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    clear_hist = 1'b0;
  endtask

  task automatic send_exp(input logic [7:0] d, input logic c,
                          input int eh, input logic el);
    int   h;
    logic l;
    model_run(d, c, h, l);
    exp_q.push_back({el, 4'(eh)});
    drive_word(d, c);
  endtask

  task automatic send_model(input logic [7:0] d, input logic c);
    int   h;
    logic l;
    model_run(d, c, h, l);
    exp_q.push_back({l, 4'(h)});
    drive_word(d, c);
  endtask

  task automatic wait_idle();
    int g = 0;
    while ((exp_q.size() != 0 || dbg_state != IDLE) && g < 200) begin
      @(posedge clk); #1;
      g++;
    end
    check("idle_reached", 32'(g < 200), 32'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    int g;
    reset_n      = 1'b0;
    in_valid     = 1'b0;
    in_data      = '0;
    clear_hist   = 1'b0;
    out_ready    = 1'b1;
    s_in_valid   = 1'b0;
    s_in_data    = '0;
    s_clear_hist = 1'b0;
    s_out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_hits", 32'(out_hits), 32'd0);
    check("rst_last_hit", 32'(out_last_hit), 32'd0);
    check("rst_core_init", 32'(dbg_core_state), 32'(INIT));
    reset_n = 1'b1;
    @(posedge clk); #1;

    // First word and its latency
    send_exp(8'hA5, 1'b1, 2, 1'b1);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency_a5", 32'(lat), 32'd8);
    wait_idle();

    // Pattern spanning a word boundary, with and without clear
    send_exp(8'h02, 1'b1, 0, 1'b0);
    send_exp(8'h80, 1'b0, 1, 1'b0);
    send_exp(8'h02, 1'b1, 0, 1'b0);
    send_exp(8'h80, 1'b1, 0, 1'b0);
    send_exp(8'hAA, 1'b1, 3, 1'b0);
    send_exp(8'h55, 1'b0, 3, 1'b1);
    wait_idle();

    // Backpressure in REPORT with a competing word on the input
    out_ready = 1'b0;
    send_exp(8'hA5, 1'b1, 2, 1'b1);
    g = 0;
    while (!out_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("bp_reached_report", 32'(out_valid), 32'd1);
    in_valid   = 1'b1;
    in_data    = 8'hFF;
    clear_hist = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_hits", 32'(out_hits), 32'd2);
      check("bp_last_hit", 32'(out_last_hit), 32'd1);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    begin
      int   h;
      logic l;
      model_run(8'hFF, 1'b0, h, l);
    end
    @(posedge clk); #1;
    check("bp_back_idle", 32'(dbg_state), 32'(IDLE));
    exp_q.push_back(5'b0_0000);  // 0xFF after S3: S1 forever, no hits
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp_ff_accepted", 32'(dbg_state), 32'(SHIFT));
    wait_idle();

    // Reset after the third bit of a word
    send_exp(8'hA5, 1'b1, 2, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_hits", 32'(out_hits), 32'd0);
    check("mid_rst_last_hit", 32'(out_last_hit), 32'd0);
    check("mid_rst_in_ready", 32'(in_ready), 32'd1);
    check("mid_rst_core_init", 32'(dbg_core_state), 32'(INIT));
    exp_q.delete();
    model_st = 0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    send_exp(8'h05, 1'b0, 1, 1'b1);
    wait_idle();

    // Random words against the reference model
    for (int i = 0; i < 12; i++) begin
      send_model(8'($urandom_range(0, 255)), ($urandom_range(0, 3) == 0));
    end
    wait_idle();

    // Hit counter saturation on the wide instance
    s_in_valid   = 1'b1;
    s_in_data    = 16'hAAAA;
    s_clear_hist = 1'b1;
    @(posedge clk); #1;
    s_in_valid   = 1'b0;
    s_clear_hist = 1'b0;
    g = 0;
    while (!s_out_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    check("sat_latency", 32'(g), 32'd16);
    check("sat_out_hits", 32'(s_out_hits), 32'd3);
    check("sat_last_hit", 32'(s_out_last_hit), 32'd0);

    @(posedge clk); #1;
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
